// File: rtl/clk_div_checker.sv
// Receive-side monitor for a divided clock sampled in the reference clock domain.
// Measures period and high time of div_clk and raises sticky period, duty and stuck-clock errors.
module clk_div_checker #(
   parameter int DIV       = 7,
   parameter int HIGH_MIN  = 3,
   parameter int HIGH_MAX  = 4,
   parameter int LOCK_CNT  = 4,
   parameter int STUCK_LIM = 32,
   localparam int CW       = $clog2(STUCK_LIM + 1)
) (
   input  logic          clk_in,
   input  logic          rst,
   input  logic          div_clk,
   input  logic          err_clr,
   output logic [CW-1:0] period_cnt,
   output logic [CW-1:0] high_cnt,
   output logic          meas_valid,
   output logic          locked,
   output logic          err_period,
   output logic          err_duty,
   output logic          err_stuck
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam logic [CW-1:0] DIV_C   = CW'(DIV);
   localparam logic [CW-1:0] HMIN_C  = CW'(HIGH_MIN);
   localparam logic [CW-1:0] HMAX_C  = CW'(HIGH_MAX);
   localparam logic [CW-1:0] STUCK_C = CW'(STUCK_LIM);
   localparam logic [GW-1:0] LOCK_C  = GW'(LOCK_CNT);
   localparam logic [GW-1:0] LOCK_M1 = GW'(LOCK_CNT - 1);

   typedef enum logic {ACQ, MEAS} state_t;

   state_t          state_reg, state_next;
   logic            div_q_reg, div_q2_reg;
   logic [CW-1:0]   cyc_cnt_reg, cyc_next;
   logic [CW-1:0]   hi_cnt_reg, hi_next;
   logic [GW-1:0]   good_cnt_reg, good_next;
   logic [CW-1:0]   period_reg, period_next;
   logic [CW-1:0]   high_reg, high_next;
   logic            meas_reg, meas_next;
   logic            locked_reg, locked_next;
   logic            err_period_reg, err_period_next;
   logic            err_duty_reg, err_duty_next;
   logic            err_stuck_reg, err_stuck_next;
   logic            set_period, set_duty, set_stuck;
   logic            rise;
   logic [CW-1:0]   cyc_inc, hi_inc;
   logic [GW-1:0]   good_inc;
   logic            period_ok, duty_ok;

   assign rise      = div_q_reg & ~div_q2_reg;
   assign cyc_inc   = (cyc_cnt_reg == STUCK_C) ? STUCK_C : cyc_cnt_reg + CW'(1);
   assign hi_inc    = (hi_cnt_reg == STUCK_C) ? STUCK_C : hi_cnt_reg + CW'(div_q_reg);
   assign good_inc  = (good_cnt_reg == LOCK_C) ? LOCK_C : good_cnt_reg + GW'(1);
   assign period_ok = (cyc_cnt_reg == DIV_C);
   assign duty_ok   = (hi_cnt_reg >= HMIN_C) && (hi_cnt_reg <= HMAX_C);

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_reg      <= ACQ;
         div_q_reg      <= 1'b0;
         div_q2_reg     <= 1'b0;
         cyc_cnt_reg    <= '0;
         hi_cnt_reg     <= '0;
         good_cnt_reg   <= '0;
         period_reg     <= '0;
         high_reg       <= '0;
         meas_reg       <= 1'b0;
         locked_reg     <= 1'b0;
         err_period_reg <= 1'b0;
         err_duty_reg   <= 1'b0;
         err_stuck_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         div_q_reg      <= div_clk;
         div_q2_reg     <= div_q_reg;
         cyc_cnt_reg    <= cyc_next;
         hi_cnt_reg     <= hi_next;
         good_cnt_reg   <= good_next;
         period_reg     <= period_next;
         high_reg       <= high_next;
         meas_reg       <= meas_next;
         locked_reg     <= locked_next;
         err_period_reg <= err_period_next;
         err_duty_reg   <= err_duty_next;
         err_stuck_reg  <= err_stuck_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cyc_next    = cyc_cnt_reg;
      hi_next     = hi_cnt_reg;
      good_next   = good_cnt_reg;
      locked_next = locked_reg;
      period_next = period_reg;
      high_next   = high_reg;
      meas_next   = 1'b0;
      set_period  = 1'b0;
      set_duty    = 1'b0;
      set_stuck   = 1'b0;
      case (state_reg)
         ACQ: begin
            // The first rise only opens a measurement window; nothing is checked here.
            if (rise) begin
               state_next = MEAS;
               cyc_next   = CW'(1);
               hi_next    = CW'(1);
            end else if (cyc_cnt_reg == STUCK_C) begin
               set_stuck = 1'b1;
               cyc_next  = '0;
            end else begin
               cyc_next = cyc_inc;
            end
         end
         MEAS: begin
            if (rise) begin
               period_next = cyc_cnt_reg;
               high_next   = hi_cnt_reg;
               meas_next   = 1'b1;
               cyc_next    = CW'(1);
               hi_next     = CW'(1);
               if (period_ok && duty_ok) begin
                  good_next = good_inc;
                  if (good_cnt_reg >= LOCK_M1)
                     locked_next = 1'b1;
               end else begin
                  good_next   = '0;
                  locked_next = 1'b0;
                  set_period  = ~period_ok;
                  set_duty    = ~duty_ok;
               end
            end else if (cyc_cnt_reg == STUCK_C) begin
               // Lost the clock: drop lock and re-acquire from scratch.
               set_stuck   = 1'b1;
               locked_next = 1'b0;
               good_next   = '0;
               state_next  = ACQ;
               cyc_next    = '0;
               hi_next     = '0;
            end else begin
               cyc_next = cyc_inc;
               hi_next  = hi_inc;
            end
         end
         default: state_next = ACQ;
      endcase
      // A flag being set on the same edge as err_clr stays set.
      err_period_next = (err_period_reg & ~err_clr) | set_period;
      err_duty_next   = (err_duty_reg & ~err_clr) | set_duty;
      err_stuck_next  = (err_stuck_reg & ~err_clr) | set_stuck;
   end

   assign period_cnt = period_reg;
   assign high_cnt   = high_reg;
   assign meas_valid = meas_reg;
   assign locked     = locked_reg;
   assign err_period = err_period_reg;
   assign err_duty   = err_duty_reg;
   assign err_stuck  = err_stuck_reg;

endmodule

// File: tb/tb_clk_div_checker.sv
// Directed bench for clk_div_checker: a table of div_clk periods with the measurement expected
// while each one is driven, plus hand-written stuck-clock and mid-period reset sequences.
module tb_clk_div_checker;

   logic       clk_in = 1'b0;
   logic       rst;
   logic       div_clk;
   logic       err_clr;
   logic [5:0] period_cnt;
   logic [5:0] high_cnt;
   logic       meas_valid;
   logic       locked;
   logic       err_period;
   logic       err_duty;
   logic       err_stuck;

   always #5 clk_in = ~clk_in;

   clk_div_checker dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .div_clk    (div_clk),
      .err_clr    (err_clr),
      .period_cnt (period_cnt),
      .high_cnt   (high_cnt),
      .meas_valid (meas_valid),
      .locked     (locked),
      .err_period (err_period),
      .err_duty   (err_duty),
      .err_stuck  (err_stuck)
   );

   // One driven period (h high, l low, optional err_clr cycle) and the measurement
   // of the previous period expected to appear while it is driven.
   typedef struct {
      int         h;
      int         l;
      int         clr;
      bit         meas;
      int         period;
      int         high;
      bit         lck;
      logic [2:0] flags;      // {err_period, err_duty, err_stuck} at the measurement
      logic [2:0] clr_flags;  // flags right after the err_clr edge
   } row_t;

   row_t       rows[23];
   int         n_cmp = 0;
   int         n_fail = 0;
   int         got_cnt;
   logic [5:0] got_period, got_high;
   logic       got_locked;
   logic [2:0] got_flags, got_clr_flags;

   function automatic row_t mk(int h, int l, int clr, bit m, int p, int hi, bit lk,
                               logic [2:0] f, logic [2:0] cf);
      row_t r;
      r.h = h; r.l = l; r.clr = clr; r.meas = m; r.period = p; r.high = hi;
      r.lck = lk; r.flags = f; r.clr_flags = cf;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic run_period(input int h, input int l, input int clr);
      got_cnt       = 0;
      got_clr_flags = '0;
      for (int c = 0; c < h + l; c++) begin
         div_clk = (c < h);
         err_clr = (c == clr);
         @(posedge clk_in);
         @(negedge clk_in);
         if (meas_valid) begin
            got_cnt++;
            got_period = period_cnt;
            got_high   = high_cnt;
            got_locked = locked;
            got_flags  = {err_period, err_duty, err_stuck};
         end
         if (c == clr) got_clr_flags = {err_period, err_duty, err_stuck};
      end
      err_clr = 1'b0;
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         run_period(rows[i].h, rows[i].l, rows[i].clr);
         $display("row %0d: h=%0d l=%0d meas=%0d period=%0d high=%0d locked=%0b flags=%03b",
                  i, rows[i].h, rows[i].l, got_cnt, got_period, got_high, got_locked, got_flags);
         check($sformatf("row%0d meas_count", i), got_cnt, rows[i].meas);
         if (rows[i].meas) begin
            check($sformatf("row%0d period_cnt", i), got_period, rows[i].period);
            check($sformatf("row%0d high_cnt", i), got_high, rows[i].high);
            check($sformatf("row%0d locked", i), got_locked, rows[i].lck);
            check($sformatf("row%0d err_flags", i), got_flags, rows[i].flags);
         end
         if (rows[i].clr >= 0)
            check($sformatf("row%0d flags_after_clr", i), got_clr_flags, rows[i].clr_flags);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " period_cnt"}, period_cnt, 0);
      check({tag, " high_cnt"}, high_cnt, 0);
      check({tag, " meas_valid"}, meas_valid, 0);
      check({tag, " locked"}, locked, 0);
      check({tag, " err_period"}, err_period, 0);
      check({tag, " err_duty"}, err_duty, 0);
      check({tag, " err_stuck"}, err_stuck, 0);
   endtask

   initial begin
      rows[0]  = mk(4, 3, -1, 0, 0, 0, 0, 3'b000, 3'b000);
      rows[1]  = mk(4, 3, -1, 1, 7, 4, 0, 3'b000, 3'b000);
      rows[2]  = mk(4, 3, -1, 1, 7, 4, 0, 3'b000, 3'b000);
      rows[3]  = mk(4, 3, -1, 1, 7, 4, 0, 3'b000, 3'b000);
      rows[4]  = mk(4, 3, -1, 1, 7, 4, 1, 3'b000, 3'b000);
      rows[5]  = mk(5, 3, -1, 1, 7, 4, 1, 3'b000, 3'b000);
      rows[6]  = mk(4, 3, -1, 1, 8, 5, 0, 3'b110, 3'b000);
      rows[7]  = mk(4, 3, -1, 1, 7, 4, 0, 3'b110, 3'b000);
      rows[8]  = mk(4, 3, -1, 1, 7, 4, 0, 3'b110, 3'b000);
      rows[9]  = mk(4, 3, -1, 1, 7, 4, 0, 3'b110, 3'b000);
      rows[10] = mk(4, 3,  3, 1, 7, 4, 1, 3'b110, 3'b000);
      rows[11] = mk(2, 5, -1, 1, 7, 4, 1, 3'b000, 3'b000);
      rows[12] = mk(4, 3, -1, 1, 7, 2, 0, 3'b010, 3'b000);
      rows[13] = mk(4, 4, -1, 1, 7, 4, 0, 3'b010, 3'b000);
      rows[14] = mk(4, 3,  1, 1, 8, 4, 0, 3'b100, 3'b100);
      rows[15] = mk(4, 3,  4, 1, 7, 4, 0, 3'b100, 3'b000);
      rows[16] = mk(4, 3, -1, 1, 7, 4, 0, 3'b000, 3'b000);
      rows[17] = mk(4, 3, -1, 1, 7, 4, 0, 3'b000, 3'b000);
      rows[18] = mk(4, 3, -1, 1, 7, 4, 1, 3'b000, 3'b000);
      rows[19] = mk(4, 3,  5, 0, 0, 0, 0, 3'b000, 3'b000);
      rows[20] = mk(4, 3, -1, 1, 7, 4, 0, 3'b000, 3'b000);
      rows[21] = mk(4, 3, -1, 0, 0, 0, 0, 3'b000, 3'b000);
      rows[22] = mk(4, 3, -1, 1, 7, 4, 0, 3'b000, 3'b000);

      rst     = 1'b1;
      div_clk = 1'b0;
      err_clr = 1'b0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      check_all_zero("reset");
      rst = 1'b0;

      // Lock, 8/5 glitch, relock, duty error, err_clr priority, relock.
      run_rows(0, 18);

      // Hold div_clk low: the last rise was captured 6 edges before this point,
      // so err_stuck must appear on the 27th extra low edge (32 after the capture).
      run_period(0, 26, -1);
      $display("stuck hold 26: err_stuck=%0b locked=%0b", err_stuck, locked);
      check("stuck_early err_stuck", err_stuck, 0);
      check("stuck_early locked", locked, 1);
      check("stuck_early meas_count", got_cnt, 0);
      run_period(0, 1, -1);
      $display("stuck hold 27: err_stuck=%0b locked=%0b", err_stuck, locked);
      check("stuck err_stuck", err_stuck, 1);
      check("stuck locked", locked, 0);
      check("stuck err_period", err_period, 0);

      // Resume: first rise only re-acquires, measurement at the second rise.
      run_rows(19, 20);

      // Reset during the low phase of a period.
      run_period(4, 1, -1);
      check("pre_reset meas_count", got_cnt, 1);
      check("pre_reset period_cnt", got_period, 7);
      rst     = 1'b1;
      div_clk = 1'b0;
      @(posedge clk_in);
      @(negedge clk_in);
      $display("mid-period reset: period=%0d locked=%0b meas=%0b", period_cnt, locked, meas_valid);
      check_all_zero("mid_reset");
      rst = 1'b0;
      run_period(0, 2, -1);
      check("post_reset meas_count", got_cnt, 0);
      run_rows(21, 22);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
